// File: rtl/mhp_eth_port_if.sv
// Byte-level bundle between the mhp protocol engine, the MAC and mhp_eth_port.
// slave modport is the port block itself; master modport is the surrounding logic.
// Signal names keep the i_/o_ direction as seen from the port block.
interface mhp_eth_port_if #(
  parameter int AW = 4
);
  logic [7:0]  i_mac_rx_data;
  logic        i_mac_rx_valid;
  logic        i_rreq;
  logic [7:0]  o_rdata;
  logic        o_rready;
  logic [7:0]  i_wdata;
  logic        i_wvalid;
  logic        o_wready;
  logic [7:0]  o_mac_tx_data;
  logic        o_mac_tx_valid;
  logic        i_mac_tx_ready;
  logic [AW:0] o_rx_count;
  logic [AW:0] o_tx_count;
  logic        o_rx_overflow;
  logic        o_tx_drop;

  modport slave (
    input  i_mac_rx_data, i_mac_rx_valid, i_rreq, i_wdata, i_wvalid, i_mac_tx_ready,
    output o_rdata, o_rready, o_wready, o_mac_tx_data, o_mac_tx_valid,
    output o_rx_count, o_tx_count, o_rx_overflow, o_tx_drop
  );

  modport master (
    output i_mac_rx_data, i_mac_rx_valid, i_rreq, i_wdata, i_wvalid, i_mac_tx_ready,
    input  o_rdata, o_rready, o_wready, o_mac_tx_data, o_mac_tx_valid,
    input  o_rx_count, o_tx_count, o_rx_overflow, o_tx_drop
  );
endinterface

// File: rtl/mhp_eth_port.sv
// Ethernet byte port: RX FIFO answering protocol read requests, TX FIFO draining to the MAC.
// Latency: read response registered one edge after the request is pending; TX is fall-through.
// Backpressure: RX has none (full FIFO drops, sticky flag); TX writes gated by o_wready.
module mhp_eth_port #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mhp_eth_port_if.slave  port
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    tx_mem_q [DEPTH];
  logic [AW-1:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
  logic [AW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic          pend_q, pend_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rready_q;
  logic          ovf_q, drop_q;
  logic          live_q;
  logic          rx_push, rx_pop, tx_push, tx_pop, tx_has, wready;

  // Push/pop decisions and next-state for the RX side; fullness uses pre-edge count.
  always_comb begin
    rx_push  = port.i_mac_rx_valid && (rx_cnt_q < FULL);
    rx_pop   = pend_q && (rx_cnt_q != '0);
    // Requests arriving while one is pending or being answered are discarded.
    pend_d   = rx_pop ? 1'b0 : (pend_q || port.i_rreq);
    rdata_d  = rx_pop ? rx_mem_q[rx_rd_q] : rdata_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + (AW+1)'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - (AW+1)'(1);
  end

  // TX side: ready is held low until the first edge after reset release.
  always_comb begin
    tx_has   = (tx_cnt_q != '0);
    wready   = live_q && (tx_cnt_q < FULL);
    tx_push  = port.i_wvalid && wready;
    tx_pop   = tx_has && port.i_mac_tx_ready;
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + (AW+1)'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - (AW+1)'(1);
  end

  // Control state, pointers, counts and sticky flags with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
      pend_q   <= 1'b0;
      rdata_q  <= '0;
      rready_q <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
      if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      pend_q   <= pend_d;
      rdata_q  <= rdata_d;
      rready_q <= rx_pop;
      if (port.i_mac_rx_valid && !rx_push) ovf_q  <= 1'b1;
      if (port.i_wvalid && !wready)        drop_q <= 1'b1;
      live_q   <= 1'b1;
    end
  end

  // Storage arrays; contents need no reset since counts gate every read.
  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= port.i_mac_rx_data;
    if (tx_push) tx_mem_q[tx_wr_q] <= port.i_wdata;
  end

  assign port.o_rdata        = rdata_q;
  assign port.o_rready       = rready_q;
  assign port.o_wready       = wready;
  assign port.o_mac_tx_valid = tx_has;
  assign port.o_mac_tx_data  = tx_has ? tx_mem_q[tx_rd_q] : 8'h00;
  assign port.o_rx_count     = rx_cnt_q;
  assign port.o_tx_count     = tx_cnt_q;
  assign port.o_rx_overflow  = ovf_q;
  assign port.o_tx_drop      = drop_q;
endmodule

// File: tb/tb_mhp_eth_port.sv
// Bench for mhp_eth_port: per-cycle vector table plus hand sequences, byte scoreboards.
module tb_mhp_eth_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   rdy_seen = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];

  mhp_eth_port_if #(.AW(4)) bus ();
  mhp_eth_port #(.DEPTH(16), .AW(4)) dut (.i_clk(clk), .i_rst(rst), .port(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic rxv; logic [7:0] rxd; logic rq;
    logic wv;  logic [7:0] wd;  logic trdy;
    int erx; int etx; logic erdy; logic etxv;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic rxv, logic [7:0] rxd, logic rq, logic wv, logic [7:0] wd,
                              logic trdy, int erx, int etx, logic erdy, logic etxv);
    vec_t v;
    v.rxv = rxv; v.rxd = rxd; v.rq = rq; v.wv = wv; v.wd = wd; v.trdy = trdy;
    v.erx = erx; v.etx = etx; v.erdy = erdy; v.etxv = etxv;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_mac_rx_data  = 8'h00;
    bus.i_mac_rx_valid = 1'b0;
    bus.i_rreq         = 1'b0;
    bus.i_wdata        = 8'h00;
    bus.i_wvalid       = 1'b0;
    bus.i_mac_tx_ready = 1'b0;
  endtask

  // Scoreboard: read responses and accepted TX bytes checked against pushed expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_rready) begin
        rdy_seen++;
        if (rx_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL rx_unexpected: rdata=%0h with no read expected", bus.o_rdata);
        end else chk("rx_byte", 32'(bus.o_rdata), 32'(rx_exp.pop_front()));
      end
      if (bus.o_mac_tx_valid && bus.i_mac_tx_ready) begin
        if (tx_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: data=%0h with no byte expected", bus.o_mac_tx_data);
        end else chk("tx_byte", 32'(bus.o_mac_tx_data), 32'(tx_exp.pop_front()));
      end
    end
  end

  initial begin
    int p0;
    idle();
    // Reset state
    repeat (2) tick();
    chk("rst_rready", 32'(bus.o_rready), 0);
    chk("rst_rdata", 32'(bus.o_rdata), 0);
    chk("rst_wready", 32'(bus.o_wready), 0);
    chk("rst_txv", 32'(bus.o_mac_tx_valid), 0);
    chk("rst_txd", 32'(bus.o_mac_tx_data), 0);
    chk("rst_rxcnt", 32'(bus.o_rx_count), 0);
    chk("rst_txcnt", 32'(bus.o_tx_count), 0);
    chk("rst_ovf", 32'(bus.o_rx_overflow), 0);
    chk("rst_drop", 32'(bus.o_tx_drop), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_wready", 32'(bus.o_wready), 1);

    // Three MAC bytes, three spaced reads; then a streamed TX burst.
    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h22, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 8'h33, 0, 0, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int b = 1; b <= 8; b++)
      tbl.push_back(mk(0, 0, 0, 1, 8'(b), 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      bus.i_mac_rx_valid = tbl[i].rxv;
      bus.i_mac_rx_data  = tbl[i].rxd;
      bus.i_rreq         = tbl[i].rq;
      bus.i_wvalid       = tbl[i].wv;
      bus.i_wdata        = tbl[i].wd;
      bus.i_mac_tx_ready = tbl[i].trdy;
      if (tbl[i].rxv) rx_exp.push_back(tbl[i].rxd);
      if (tbl[i].wv)  tx_exp.push_back(tbl[i].wd);
      tick();
      chk($sformatf("v%0d_rxcnt", i), 32'(bus.o_rx_count), 32'(tbl[i].erx));
      chk($sformatf("v%0d_txcnt", i), 32'(bus.o_tx_count), 32'(tbl[i].etx));
      chk($sformatf("v%0d_rready", i), 32'(bus.o_rready), 32'(tbl[i].erdy));
      chk($sformatf("v%0d_txv", i), 32'(bus.o_mac_tx_valid), 32'(tbl[i].etxv));
      chk($sformatf("v%0d_wready", i), 32'(bus.o_wready), 1);
    end
    idle();
    tick();
    chk("t5_drop", 32'(bus.o_tx_drop), 0);

    // Read request on an empty FIFO, with a held request during the wait.
    p0 = rdy_seen;
    bus.i_rreq = 1'b1;
    repeat (5) tick();
    bus.i_rreq = 1'b0;
    repeat (5) tick();
    chk("t2_no_early_pulse", 32'(rdy_seen - p0), 0);
    bus.i_mac_rx_valid = 1'b1;
    bus.i_mac_rx_data  = 8'hA5;
    rx_exp.push_back(8'hA5);
    tick();
    bus.i_mac_rx_valid = 1'b0;
    chk("t2_rready_M", 32'(bus.o_rready), 0);
    tick();
    chk("t2_rready_M1", 32'(bus.o_rready), 1);
    chk("t2_rdata", 32'(bus.o_rdata), 32'hA5);
    repeat (4) tick();
    chk("t2_one_pulse", 32'(rdy_seen - p0), 1);
    chk("t2_rdata_hold", 32'(bus.o_rdata), 32'hA5);

    // RX overflow: 17 bytes into a 16-deep FIFO, then drain.
    for (int i = 0; i < 17; i++) begin
      bus.i_mac_rx_valid = 1'b1;
      bus.i_mac_rx_data  = 8'(i);
      if (i < 16) rx_exp.push_back(8'(i));
      tick();
    end
    bus.i_mac_rx_valid = 1'b0;
    chk("t3_rxcnt_full", 32'(bus.o_rx_count), 16);
    chk("t3_ovf", 32'(bus.o_rx_overflow), 1);
    bus.i_rreq = 1'b1;
    repeat (32) tick();
    bus.i_rreq = 1'b0;
    repeat (3) tick();
    chk("t3_rxcnt_empty", 32'(bus.o_rx_count), 0);
    chk("t3_all_read", 32'(rx_exp.size()), 0);
    chk("t3_ovf_sticky", 32'(bus.o_rx_overflow), 1);

    // TX full with MAC stalled, dropped 17th write, then drain.
    bus.i_mac_tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.i_wvalid = 1'b1;
      bus.i_wdata  = 8'hB0 + 8'(i);
      tx_exp.push_back(8'hB0 + 8'(i));
      tick();
    end
    bus.i_wvalid = 1'b0;
    chk("t4_wready_full", 32'(bus.o_wready), 0);
    chk("t4_txcnt_full", 32'(bus.o_tx_count), 16);
    chk("t4_drop_pre", 32'(bus.o_tx_drop), 0);
    bus.i_wvalid = 1'b1;
    bus.i_wdata  = 8'hEE;
    tick();
    bus.i_wvalid = 1'b0;
    chk("t4_drop", 32'(bus.o_tx_drop), 1);
    chk("t4_txcnt_after_drop", 32'(bus.o_tx_count), 16);
    bus.i_mac_tx_ready = 1'b1;
    repeat (20) tick();
    chk("t4_txcnt_drained", 32'(bus.o_tx_count), 0);
    chk("t4_txv_drained", 32'(bus.o_mac_tx_valid), 0);
    chk("t4_all_sent", 32'(tx_exp.size()), 0);
    chk("t4_wready_back", 32'(bus.o_wready), 1);
    idle();
    tick();

    // Reset during the response window and a stalled TX burst.
    bus.i_mac_rx_valid = 1'b1;
    bus.i_mac_rx_data  = 8'h5A;
    bus.i_wvalid       = 1'b1;
    bus.i_wdata        = 8'hC1;
    tick();
    bus.i_mac_rx_valid = 1'b0;
    bus.i_rreq         = 1'b1;
    bus.i_wdata        = 8'hC2;
    tick();
    idle();
    rst = 1'b1;
    rx_exp.delete();
    tx_exp.delete();
    p0 = rdy_seen;
    tick();
    chk("t6_rready", 32'(bus.o_rready), 0);
    chk("t6_txv", 32'(bus.o_mac_tx_valid), 0);
    chk("t6_rxcnt", 32'(bus.o_rx_count), 0);
    chk("t6_txcnt", 32'(bus.o_tx_count), 0);
    chk("t6_ovf", 32'(bus.o_rx_overflow), 0);
    chk("t6_drop", 32'(bus.o_tx_drop), 0);
    chk("t6_wready_in_rst", 32'(bus.o_wready), 0);
    rst = 1'b0;
    tick();
    chk("t6_rready_after", 32'(bus.o_rready), 0);
    chk("t6_wready_after", 32'(bus.o_wready), 1);
    bus.i_mac_rx_valid = 1'b1;
    bus.i_mac_rx_data  = 8'h77;
    rx_exp.push_back(8'h77);
    bus.i_wvalid       = 1'b1;
    bus.i_wdata        = 8'h99;
    tx_exp.push_back(8'h99);
    bus.i_mac_tx_ready = 1'b1;
    tick();
    bus.i_mac_rx_valid = 1'b0;
    bus.i_wvalid       = 1'b0;
    bus.i_rreq         = 1'b1;
    tick();
    bus.i_rreq = 1'b0;
    tick();
    chk("t6_resume_rready", 32'(bus.o_rready), 1);
    chk("t6_resume_rdata", 32'(bus.o_rdata), 32'h77);
    idle();
    repeat (3) tick();
    chk("t6_one_pulse", 32'(rdy_seen - p0), 1);
    chk("t6_txcnt_final", 32'(bus.o_tx_count), 0);
    chk("end_rx_queue", 32'(rx_exp.size()), 0);
    chk("end_tx_queue", 32'(tx_exp.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
